// File: rtl/bfu_fft_pkg.sv
// Shared definitions for the radix-2 DIF FFT stage blocks.
//
// Contents:
//   SAMPLE_W        width of one packed complex sample
//   RE_* / IM_*     bit bounds of the real and imaginary fields
//   feeder_state_e  pair-feeder FSM states (FILL, PAIR)
//   pack_sample()   builds a packed sample from real/imag halves
package bfu_fft_pkg;

    localparam int SAMPLE_W = 32;
    localparam int RE_LSB   = 0;
    localparam int RE_MSB   = 15;
    localparam int IM_LSB   = 16;
    localparam int IM_MSB   = 31;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PAIR = 1'b1
    } feeder_state_e;

    function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [RE_MSB-RE_LSB:0] re,
                                                        input logic [IM_MSB-IM_LSB:0] im);
        return {im, re};
    endfunction

endpackage

// File: rtl/bfu_half_buf.sv
// Half-frame sample buffer for the pair feeder.
//
// DEPTH x SAMPLE_W storage, one synchronous write port and one
// asynchronous read port. Contents are not reset; every slot is written
// before it is read within a frame.
//
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write slot
//   wr_data  in   write sample
//   rd_addr  in   read slot
//   rd_data  out  sample in rd_addr (combinational)
module bfu_half_buf
    import bfu_fft_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/bfu_dif_pair_feeder.sv
// Input stage of a radix-2 DIF FFT pipeline stage.
//
// Buffers the first half of each N-point frame, then during the second
// half emits the butterfly pair x[n], x[n+N/2] with its twiddle address.
// All outputs are registered: a pair appears one cycle after the edge
// that accepts its lower (b) sample.
//
// Optional feature: define BFU_FEEDER_FRAME_CHK_EN to check in_sof against
// the sample counter, raise a sticky sync_err on a mismatch and resync on
// a misplaced in_sof. Without it in_sof is ignored and sync_err is 0.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   synchronous reset, active HIGH despite the name
//   in_data    in   packed sample {imag, real}
//   in_valid   in   in_data accepted on this edge
//   in_sof     in   first sample of a frame (qualified by in_valid)
//   a          out  upper butterfly input x[n]
//   b          out  lower butterfly input x[n+N/2]
//   tw_addr    out  twiddle ROM address for this pair
//   out_valid  out  a/b/tw_addr valid this cycle
//   out_sof    out  first pair of a frame
//   sync_err   out  sticky frame-alignment error
//
// Handshake: no backpressure. A sample is consumed on every edge where
// in_valid=1; out_valid is a one-cycle strobe that downstream must take.
module bfu_dif_pair_feeder
    import bfu_fft_pkg::*;
#(
    parameter int FFT_POINTS   = 8,
    parameter int TW_ROM_DEPTH = 4,
    parameter int TW_STRIDE    = 1,
    parameter int ADDR_W       = $clog2(TW_ROM_DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_sof,
    output logic [SAMPLE_W-1:0] a,
    output logic [SAMPLE_W-1:0] b,
    output logic [ADDR_W-1:0]   tw_addr,
    output logic                out_valid,
    output logic                out_sof,
    output logic                sync_err
);

    localparam int HALF   = FFT_POINTS / 2;
    localparam int CNT_W  = $clog2(FFT_POINTS);
    localparam int HB_W   = CNT_W - 1;
    localparam int PROD_W = ADDR_W + CNT_W;

    feeder_state_e       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] a_q, a_d;
    logic [SAMPLE_W-1:0] b_q, b_d;
    logic [ADDR_W-1:0]   tw_q, tw_d;
    logic                out_valid_q, out_valid_d;
    logic                out_sof_q, out_sof_d;
    logic                sync_err_q, sync_err_d;

    // Counter/state as seen by this sample after any resync.
    feeder_state_e       eff_state;
    logic [CNT_W-1:0]    eff_cnt;
    logic                frame_mismatch;

    logic                wr_en;
    logic [HB_W-1:0]     rd_addr;
    logic [SAMPLE_W-1:0] rd_data;
    logic [PROD_W-1:0]   tw_prod;

    always_comb begin
        eff_state      = state_q;
        eff_cnt        = cnt_q;
        frame_mismatch = 1'b0;
`ifdef BFU_FEEDER_FRAME_CHK_EN
        frame_mismatch = in_valid && (in_sof != (cnt_q == '0));
        // A misplaced in_sof restarts the frame; a pair in progress is lost.
        if (frame_mismatch && in_sof) begin
            eff_state = ST_FILL;
            eff_cnt   = '0;
        end
`endif
    end

`ifndef BFU_FEEDER_FRAME_CHK_EN
    logic unused_in_sof;
    assign unused_in_sof = in_sof;
`endif

    // In PAIR the counter MSB is set, so cnt-N/2 is just its low bits.
    // A resync only ever lands in FILL, so the read slot never needs eff_cnt.
    assign rd_addr = cnt_q[HB_W-1:0];

    bfu_half_buf #(
        .DEPTH (HALF)
    ) u_half_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (eff_cnt[HB_W-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        tw_d        = tw_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
`ifdef BFU_FEEDER_FRAME_CHK_EN
        sync_err_d  = sync_err_q | frame_mismatch;
`else
        sync_err_d  = 1'b0;
`endif
        wr_en       = 1'b0;
        tw_prod     = '0;

        if (in_valid) begin
            // N is a power of two, so N-1 + 1 wraps to 0 on its own.
            cnt_d = eff_cnt + CNT_W'(1);
            if (eff_state == ST_FILL) begin
                wr_en = 1'b1;
                if (eff_cnt == CNT_W'(HALF - 1)) begin
                    state_d = ST_PAIR;
                end
            end else begin
                out_valid_d = 1'b1;
                out_sof_d   = (eff_cnt == CNT_W'(HALF));
                a_d         = rd_data;
                b_d         = in_data;
                tw_prod     = PROD_W'(eff_cnt[HB_W-1:0]) * PROD_W'(TW_STRIDE);
                tw_d        = ADDR_W'(tw_prod % PROD_W'(TW_ROM_DEPTH));
                if (eff_cnt == CNT_W'(FFT_POINTS - 1)) begin
                    state_d = ST_FILL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tw_q        <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tw_q        <= tw_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign tw_addr   = tw_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_bfu_dif_pair_feeder.sv
// Bench for bfu_dif_pair_feeder: an N=8 instance and an N=16/stride-2
// instance, each checked every cycle against a frame-level model, plus
// literal pair lists for each directed scenario.
module tb_bfu_dif_pair_feeder;
    import bfu_fft_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8 = 1'b1, v8 = 1'b0, sof8 = 1'b0;
    logic [31:0] d8 = '0;
    logic [31:0] a8, b8;
    logic [1:0]  tw8;
    logic        ov8, os8, se8;

    logic        rst16 = 1'b1, v16 = 1'b0, sof16 = 1'b0;
    logic [31:0] d16 = '0;
    logic [31:0] a16, b16;
    logic [2:0]  tw16;
    logic        ov16, os16, se16;

    bfu_dif_pair_feeder #(.FFT_POINTS(8), .TW_ROM_DEPTH(4), .TW_STRIDE(1)) dut8 (
        .clk(clk), .reset_n(rst8), .in_data(d8), .in_valid(v8), .in_sof(sof8),
        .a(a8), .b(b8), .tw_addr(tw8), .out_valid(ov8), .out_sof(os8), .sync_err(se8));

    bfu_dif_pair_feeder #(.FFT_POINTS(16), .TW_ROM_DEPTH(8), .TW_STRIDE(2)) dut16 (
        .clk(clk), .reset_n(rst16), .in_data(d16), .in_valid(v16), .in_sof(sof16),
        .a(a16), .b(b16), .tw_addr(tw16), .out_valid(ov16), .out_sof(os16), .sync_err(se16));

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    // Instance 0: N=8, depth 4, stride 1. Instance 1: N=16, depth 8, stride 2.
    int          pos [2];
    logic [31:0] hb  [2][8];
    logic [31:0] ea  [2];
    logic [31:0] eb  [2];
    int          etw [2];
    logic        ev  [2];
    logic        es  [2];
    logic        ee  [2];

    task automatic model_step(input int i, input logic rst, input logic v,
                              input logic s, input logic [31:0] d);
        int n, stride, depth, k;
        n      = (i == 0) ? 8 : 16;
        stride = (i == 0) ? 1 : 2;
        depth  = (i == 0) ? 4 : 8;
        if (rst) begin
            pos[i] = 0; ea[i] = '0; eb[i] = '0; etw[i] = 0;
            ev[i] = 1'b0; es[i] = 1'b0; ee[i] = 1'b0;
            return;
        end
        ev[i] = 1'b0;
        es[i] = 1'b0;
        if (!v) return;
        k = pos[i];
`ifdef BFU_FEEDER_FRAME_CHK_EN
        if (s != (k == 0)) ee[i] = 1'b1;
        if (s && k != 0) k = 0;
`else
        if (s) k = pos[i];
`endif
        if (k < n / 2) begin
            hb[i][k] = d;
        end else begin
            ea[i]  = hb[i][k - n / 2];
            eb[i]  = d;
            etw[i] = ((k - n / 2) * stride) % depth;
            ev[i]  = 1'b1;
            es[i]  = (k == n / 2);
        end
        pos[i] = (k + 1) % n;
    endtask

    always @(posedge clk) begin
        model_step(0, rst8, v8, sof8, d8);
        model_step(1, rst16, v16, sof16, d16);
    end

    // ---------------- compare process ----------------
    logic [31:0] obs8_q[$];
    logic [31:0] obs16_q[$];
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ov8",  32'(ov8), 32'(ev[0]));
            chk("sof8", 32'(os8), 32'(es[0]));
            chk("a8",   a8, ea[0]);
            chk("b8",   b8, eb[0]);
            chk("tw8",  32'(tw8), 32'(etw[0]));
            chk("err8", 32'(se8), 32'(ee[0]));
            chk("ov16", 32'(ov16), 32'(ev[1]));
            chk("sof16", 32'(os16), 32'(es[1]));
            chk("a16",  a16, ea[1]);
            chk("b16",  b16, eb[1]);
            chk("tw16", 32'(tw16), 32'(etw[1]));
            chk("err16", 32'(se16), 32'(ee[1]));
            if (ov8)  obs8_q.push_back({7'b0, os8, 6'b0, tw8, b8[7:0], a8[7:0]});
            if (ov16) obs16_q.push_back({7'b0, os16, 5'b0, tw16, b16[7:0], a16[7:0]});
        end
    end

    // ---------------- drivers ----------------
    task automatic drive8(input logic v, input logic s, input logic [31:0] d);
        v8 = v; sof8 = s; d8 = d;
        @(posedge clk); #1;
    endtask

    task automatic drive16(input logic v, input logic s, input logic [31:0] d);
        v16 = v; sof16 = s; d16 = d;
        @(posedge clk); #1;
    endtask

    task automatic frame8(input int base, input int gap, input int im);
        for (int k = 0; k < 8; k++) begin
            drive8(1'b1, k == 0, pack_sample(16'(base + k), 16'(im * k)));
            if (gap != 0) drive8(1'b0, 1'b0, 32'hdead_beef);
        end
    endtask

    task automatic idle8(input int n);
        for (int i = 0; i < n; i++) drive8(1'b0, 1'b0, '0);
    endtask

    // Literal expectation: pairs (base+j, base+j+half), twiddle from list.
    int tw16_lit[8];

    task automatic expect_burst(input int which, input int abase);
        int half, tw;
        half = (which == 0) ? 4 : 8;
        for (int j = 0; j < half; j++) begin
            tw = (which == 0) ? j : tw16_lit[j];
            exp_q.push_back(32'(((j == 0) ? 1 : 0) << 24) | 32'(tw << 16)
                            | 32'(((abase + j + half) & 255) << 8) | 32'((abase + j) & 255));
        end
    endtask

    task automatic check_obs(input int which, input string name);
        logic [31:0] o;
        while (exp_q.size() > 0) begin
            if (which == 0) o = (obs8_q.size() > 0) ? obs8_q.pop_front() : 32'hffff_ffff;
            else            o = (obs16_q.size() > 0) ? obs16_q.pop_front() : 32'hffff_ffff;
            chk(name, o, exp_q.pop_front());
        end
        chk({name, "_extra"}, (which == 0) ? obs8_q.size() : obs16_q.size(), 0);
        obs8_q.delete();
        obs16_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tw16_lit = '{0, 2, 4, 6, 0, 2, 4, 6};
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        chk("rst_a", a8, 32'h0);
        chk("rst_b", b8, 32'h0);
        chk("rst_tw", 32'(tw8), 32'h0);
        chk("rst_ov", 32'(ov8), 32'h0);
        chk("rst_err", 32'(se8), 32'h0);
        rst8 = 1'b0;
        rst16 = 1'b0;

        // Continuous frame; first pair must show one cycle after k=4.
        for (int k = 0; k < 5; k++) drive8(1'b1, k == 0, 32'(k));
        chk("lat_first", {31'b0, ov8}, 32'h1);
        chk("lat_a", a8, 32'h0);
        chk("lat_b", b8, 32'h4);
        for (int k = 5; k < 8; k++) drive8(1'b1, 1'b0, 32'(k));
        idle8(2);
        expect_burst(0, 0);
        check_obs(0, "cont");

        // Every other cycle idle.
        frame8(0, 1, 0);
        idle8(2);
        expect_burst(0, 0);
        check_obs(0, "gapped");

        // Back-to-back frames, second one offset by 16.
        frame8(0, 0, 0);
        frame8(16, 0, 0);
        idle8(2);
        expect_burst(0, 0);
        expect_burst(0, 16);
        check_obs(0, "b2b");

        // Non-zero (negative) imaginary parts.
        frame8(100, 0, -3);
        idle8(2);
        expect_burst(0, 100);
        check_obs(0, "imag");

        // Reset after 6 samples, reset beats in_valid on the same edge.
        for (int k = 0; k < 6; k++) drive8(1'b1, k == 0, 32'(k));
        rst8 = 1'b1;
        drive8(1'b1, 1'b0, 32'd99);
        rst8 = 1'b0;
        chk("rst_mid_ov", {31'b0, ov8}, 32'h0);
        frame8(40, 0, 0);
        idle8(2);
        exp_q.push_back(32'h0100_0400);
        exp_q.push_back(32'h0001_0501);
        expect_burst(0, 40);
        check_obs(0, "rst_mid");

        // in_sof on k=2.
        for (int k = 0; k < 10; k++) begin
            drive8(1'b1, (k == 0) || (k == 2), 32'(k));
            if (k == 2) begin
`ifdef BFU_FEEDER_FRAME_CHK_EN
                chk("sync_err_set", {31'b0, se8}, 32'h1);
`else
                chk("sync_err_off", {31'b0, se8}, 32'h0);
`endif
            end
        end
        idle8(2);
`ifdef BFU_FEEDER_FRAME_CHK_EN
        expect_burst(0, 2);
`else
        expect_burst(0, 0);
`endif
        check_obs(0, "resync");
        rst8 = 1'b1;
        idle8(1);
        rst8 = 1'b0;
        chk("err_cleared", {31'b0, se8}, 32'h0);

        // N=16, depth 8, stride 2.
        for (int k = 0; k < 16; k++) drive16(1'b1, k == 0, 32'(k));
        for (int i = 0; i < 2; i++) drive16(1'b0, 1'b0, '0);
        expect_burst(1, 0);
        check_obs(1, "n16");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bfu_dif_pair_feeder.md
# bfu_dif_pair_feeder

Input stage of one radix-2 DIF FFT pipeline stage. It takes a serial stream of complex samples and buffers the first half of each N-point frame. During the second half it presents the butterfly pairs x[n], x[n+N/2] on `a`/`b`, together with the matching twiddle ROM address, for the `bfu_dif_top` butterfly directly downstream. Samples are packed one 32-bit word each: imag in [31:16], real in [15:0], two's complement.

## Interface
- `FFT_POINTS`, 8: frame length N; power of two, ≥ 4.
- `TW_ROM_DEPTH`, 4: depth of the downstream twiddle ROM.
- `TW_STRIDE`, 1: twiddle address increment per pair.
- `ADDR_W`, $clog2(TW_ROM_DEPTH): twiddle address width.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset_n`  in  1  reset; synchronous, active-high (asserted = 1) despite the `_n` suffix.
- `in_data`  in  32  input sample.
- `in_valid`  in  1  `in_data` is accepted on this edge.
- `in_sof`  in  1  first sample of a frame; qualified by `in_valid`.
- `a`  out  32  upper butterfly input, x[n].
- `b`  out  32  lower butterfly input, x[n+N/2].
- `tw_addr`  out  ADDR_W  twiddle address for this pair.
- `out_valid`  out  1  `a`/`b`/`tw_addr` hold a valid pair this cycle.
- `out_sof`  out  1  first pair of a frame; only high together with `out_valid`.
- `sync_err`  out  1  sticky frame-alignment error.

## Operation
- Sample counter `cnt` has range 0..N-1 and advances only on accepted samples (`in_valid`=1). Input gaps of any length hold all state.
- FSM has two states:
  - FILL, `cnt` 0..N/2-1: write `in_data` into half-buffer slot `cnt`; no output.
  - PAIR, `cnt` N/2..N-1: read slot `cnt`-N/2 as `a`, take `in_data` as `b`.
  - FILL → PAIR when `cnt` = N/2-1 is accepted. PAIR → FILL when `cnt` = N-1 is accepted; `cnt` wraps to 0.
- Twiddle address: `tw_addr` = ((`cnt`-N/2)·TW_STRIDE) mod TW_ROM_DEPTH, where the product is computed ADDR_W+$clog2(N) bits wide before the modulo.
- `out_sof` is high for the pair built from `cnt` = N/2.
- No backpressure: the downstream stage always accepts. Output occupancy is therefore at most 50% over a frame.
- Half-buffer contents are never cleared. Each slot is always written before it is read.

## Timing
- All outputs are registered.
- Latency: the pair appears one cycle after the edge that accepts its `b` sample.
- `out_valid` is high for exactly one cycle per accepted PAIR-phase sample. `a`, `b` and `tw_addr` hold their last values while `out_valid`=0.
- Reset values: `a`=0, `b`=0, `tw_addr`=0, `out_valid`=0, `out_sof`=0, `sync_err`=0. State is FILL with `cnt`=0.
- Reset has priority over `in_valid` on the same edge.
- Reset mid-frame discards the partial frame. The first accepted sample after reset is `cnt`=0.
- Back-to-back frames need no idle cycle: the sample accepted on the edge after `cnt`=N-1 is `cnt`=0 of the next frame.

## Configuration
- Macro: `BFU_FEEDER_FRAME_CHK_EN`.
- Defined:
  - Each accepted sample is checked against `in_sof`. A mismatch is `in_sof`=1 with `cnt`≠0, or `in_sof`=0 with `cnt`=0.
  - On a mismatch, `sync_err` is set the next cycle and stays set until reset.
  - Also on a mismatch, an `in_sof`=1 sample forces a resync: it is treated as `cnt`=0, state goes to FILL, and any pair under construction is dropped.
  - An `in_sof`=0 sample at `cnt`=0 is still accepted normally as `cnt`=0.
- Undefined: `in_sof` is ignored, `sync_err` is tied to 0, and the counter free-runs.
- Ports are identical in both builds.

## Structure
- Shared package `bfu_fft_pkg` holds:
  - `SAMPLE_W`=32 and the real/imag field bounds.
  - The FSM state typedef (FILL, PAIR).
- Sub-module `bfu_half_buf`: N/2 × 32 storage with one synchronous write port and one asynchronous read port. Not reset.

## Test plan
All scenarios use N=8, TW_ROM_DEPTH=4, TW_STRIDE=1 unless stated.

- Continuous frame, real=k, imag=0 for k=0..7, `in_sof` on k=0 → four consecutive `out_valid` cycles, starting one cycle after k=4 is accepted. Pairs are (0,4), (1,5), (2,6), (3,7) with `tw_addr` 0,1,2,3 and `out_sof` on the first pair.
- Same frame with `in_valid` low every other cycle → identical pairs; each appears one cycle after its `b` is accepted, with gaps matching the input.
- Two back-to-back frames, second frame real=k+16 → second burst pairs are (16,20)…(19,23) and `tw_addr` restarts at 0.
- N=16, TW_ROM_DEPTH=8, TW_STRIDE=2 → `tw_addr` sequence 0,2,4,6,0,2,4,6.
- Reset asserted after 6 samples, then a fresh frame 0..7 → no output until the fresh frame's k=4, after which the pairs are correct.
- With `BFU_FEEDER_FRAME_CHK_EN`, `in_sof` on k=2 → `sync_err`=1 the next cycle. That sample becomes `cnt`=0 and the following pairs are aligned to it.
